// File: rtl/info_navigator_pkg.sv
// Shared types and constants for the info navigator: views, select codes,
// view sizes and the capture FSM state encoding.
package info_pkg;

    typedef enum logic [1:0] {
        VIEW_INSTR,
        VIEW_REG,
        VIEW_MEM
    } view_e;

    typedef enum logic {
        S_IDLE,
        S_LATCH
    } state_e;

    localparam logic [1:0] SEL_INSTR = 2'd0;
    localparam logic [1:0] SEL_REG   = 2'd1;
    localparam logic [1:0] SEL_MEM   = 2'd3;

    localparam int unsigned SIZE_INSTR = 256;
    localparam int unsigned SIZE_REG   = 32;
    localparam int unsigned SIZE_MEM   = 1024;

    // Mode button walks INSTR -> REG -> MEM -> INSTR.
    function automatic view_e view_next(input view_e v);
        case (v)
            VIEW_INSTR: view_next = VIEW_REG;
            VIEW_REG:   view_next = VIEW_MEM;
            default:    view_next = VIEW_INSTR;
        endcase
    endfunction

    // Select code presented to the word source; code 2 is never produced.
    function automatic logic [1:0] view_select(input view_e v);
        case (v)
            VIEW_INSTR: view_select = SEL_INSTR;
            VIEW_REG:   view_select = SEL_REG;
            default:    view_select = SEL_MEM;
        endcase
    endfunction

    // Highest legal index of a view, used as the counter wrap limit.
    function automatic logic [9:0] view_last(input view_e v);
        case (v)
            VIEW_INSTR: view_last = 10'(SIZE_INSTR - 1);
            VIEW_REG:   view_last = 10'(SIZE_REG - 1);
            default:    view_last = 10'(SIZE_MEM - 1);
        endcase
    endfunction

endpackage

// File: rtl/info_navigator_view_index_counter.sv
// 10-bit up/down index counter with synchronous clear and a runtime wrap
// limit: up wraps limit -> 0, down wraps 0 -> limit.
module view_index_counter
    import info_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic       dec_i,
    input  logic [9:0] limit_i,
    output logic [9:0] count_o
);

    logic [9:0] count_q;
    logic [9:0] count_d;

    // Next index: clear wins, then increment, then decrement, with wrap.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = (count_q == limit_i) ? '0 : count_q + 10'd1;
        end else if (dec_i) begin
            count_d = (count_q == '0) ? limit_i : count_q - 10'd1;
        end
    end

    // Index register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/info_navigator.sv
// Info navigator: steps through instruction/register/data-memory views by
// button or auto-advance, and captures the addressed word one cycle after
// every accepted event (or periodic refresh).
module info_navigator
    import info_pkg::*;
#(
    parameter int unsigned AUTO_PERIOD    = 50_000_000,
    parameter int unsigned REFRESH_PERIOD = 1_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btnNext,
    input  logic        btnPrev,
    input  logic        btnMode,
    input  logic        btnAuto,
    input  logic [31:0] word,
    output logic [1:0]  select,
    output logic [9:0]  derreference,
    output logic [31:0] shownWord,
    output logic [9:0]  shownAddress,
    output logic        autoActive
);

    localparam int unsigned AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam int unsigned RW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_PERIOD - 1);

    state_e        state_q, state_d;
    view_e         view_q, view_d;
    logic          auto_q, auto_d;
    logic [AW-1:0] auto_cnt_q, auto_cnt_d;
    logic [RW-1:0] ref_cnt_q, ref_cnt_d;
    logic [31:0]   shown_word_q;
    logic [9:0]    shown_addr_q;
    logic [9:0]    index;

    logic auto_tick, ref_tick;
    logic ev_mode, ev_next, ev_prev, ev_auto, ev_ref, btn_ev;

    assign auto_tick = auto_q && (auto_cnt_q == AUTO_LAST);
    assign ref_tick  = (ref_cnt_q == REF_LAST);
    assign btn_ev    = ev_mode | ev_next | ev_prev;

    view_index_counter u_index (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (ev_mode),
        .inc_i   (ev_next | ev_auto),
        .dec_i   (ev_prev),
        .limit_i (view_last(view_q)),
        .count_o (index)
    );

    // FSM next state and prioritised event acceptance (only in S_IDLE).
    always_comb begin
        state_d = state_q;
        ev_mode = 1'b0;
        ev_next = 1'b0;
        ev_prev = 1'b0;
        ev_auto = 1'b0;
        ev_ref  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (btnMode) begin
                    ev_mode = 1'b1;
                end else if (btnNext) begin
                    ev_next = 1'b1;
                end else if (btnPrev) begin
                    ev_prev = 1'b1;
                end else if (auto_tick) begin
                    ev_auto = 1'b1;
                end else if (ref_tick) begin
                    ev_ref = 1'b1;
                end
                if (btnMode || btnNext || btnPrev || auto_tick || ref_tick) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // View, auto-enable and the two tick counters; pending ticks saturate
    // at their last value so a tick dropped by priority is taken later.
    always_comb begin
        view_d = ev_mode ? view_next(view_q) : view_q;
        auto_d = auto_q ^ btnAuto;

        auto_cnt_d = auto_cnt_q;
        if (btnAuto || ev_auto) begin
            auto_cnt_d = '0;
        end else if (auto_q && (auto_cnt_q != AUTO_LAST)) begin
            auto_cnt_d = auto_cnt_q + AW'(1);
        end

        ref_cnt_d = ref_cnt_q;
        if (ev_ref || btn_ev) begin
            ref_cnt_d = '0;
        end else if (ref_cnt_q != REF_LAST) begin
            ref_cnt_d = ref_cnt_q + RW'(1);
        end
    end

    // State registers; reset enters S_LATCH so word 0 is captured at once.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_LATCH;
            view_q       <= VIEW_INSTR;
            auto_q       <= 1'b0;
            auto_cnt_q   <= '0;
            ref_cnt_q    <= '0;
            shown_word_q <= '0;
            shown_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            view_q     <= view_d;
            auto_q     <= auto_d;
            auto_cnt_q <= auto_cnt_d;
            ref_cnt_q  <= ref_cnt_d;
            if (state_q == S_LATCH) begin
                shown_word_q <= word;
                shown_addr_q <= index;
            end
        end
    end

    assign select       = view_select(view_q);
    assign derreference = index;
    assign shownWord    = shown_word_q;
    assign shownAddress = shown_addr_q;
    assign autoActive   = auto_q;

endmodule

// File: tb/tb_info_navigator.sv
// Directed bench for info_navigator: instance A (fast auto-advance) covers
// navigation, wrap, priority and reset; instance B (fast refresh) covers
// periodic re-capture of a changing word.
module tb_info_navigator;

    logic        clk = 1'b0;
    logic        rst;
    logic        nx_a, pv_a, md_a, au_a;
    logic [31:0] word_a;
    logic [1:0]  sel_a;
    logic [9:0]  der_a;
    logic [31:0] sw_a;
    logic [9:0]  sa_a;
    logic        act_a;

    logic        nx_b, pv_b, md_b, au_b;
    logic [31:0] word_b;
    logic [1:0]  sel_b;
    logic [9:0]  der_b;
    logic [31:0] sw_b;
    logic [9:0]  sa_b;
    logic        act_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    info_navigator #(.AUTO_PERIOD(4), .REFRESH_PERIOD(1_000_000)) dut_a (
        .clock(clk), .reset(rst), .btnNext(nx_a), .btnPrev(pv_a),
        .btnMode(md_a), .btnAuto(au_a), .word(word_a), .select(sel_a),
        .derreference(der_a), .shownWord(sw_a), .shownAddress(sa_a),
        .autoActive(act_a)
    );

    info_navigator #(.AUTO_PERIOD(4), .REFRESH_PERIOD(8)) dut_b (
        .clock(clk), .reset(rst), .btnNext(nx_b), .btnPrev(pv_b),
        .btnMode(md_b), .btnAuto(au_b), .word(word_b), .select(sel_b),
        .derreference(der_b), .shownWord(sw_b), .shownAddress(sa_b),
        .autoActive(act_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One-cycle pulse {mode,next,prev,auto} followed by one idle cycle
    // so the capture cycle has passed before the next pulse.
    task automatic press(input logic [3:0] m);
        {md_a, nx_a, pv_a, au_a} = m;
        tick();
        {md_a, nx_a, pv_a, au_a} = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        {md_a, nx_a, pv_a, au_a} = 4'b0000;
        {md_b, nx_b, pv_b, au_b} = 4'b0000;
        word_a = 32'hDEADBEEF;
        word_b = 32'h1;
        tick();
        tick();
        check("rst_select", 32'(sel_a), 32'd0);
        check("rst_index", 32'(der_a), 32'd0);
        check("rst_shownWord", sw_a, 32'd0);
        check("rst_shownAddr", 32'(sa_a), 32'd0);
        check("rst_auto", 32'(act_a), 32'd0);

        rst = 1'b0;
        tick();
        tick();
        check("first_capture_word", sw_a, 32'hDEADBEEF);
        check("first_capture_addr", 32'(sa_a), 32'd0);
        check("first_capture_sel", 32'(sel_a), 32'd0);
        check("b_first_capture", sw_b, 32'h1);

        // Periodic refresh picks up a changed word with no buttons.
        word_b = 32'h2;
        for (int i = 0; i < 10 && sw_b !== 32'h2; i++) tick();
        check("refresh_word", sw_b, 32'h2);
        check("refresh_index", 32'(der_b), 32'd0);

        // REG view, wrap down and up.
        press(4'b1000);
        check("mode_to_reg", 32'(sel_a), 32'd1);
        press(4'b0010);
        check("reg_prev_wrap", 32'(der_a), 32'd31);
        check("reg_prev_capture", 32'(sa_a), 32'd31);
        press(4'b0100);
        check("reg_next_wrap", 32'(der_a), 32'd0);

        // MEM view; next beats prev; mode returns to INSTR.
        press(4'b1000);
        check("mode_to_mem", 32'(sel_a), 32'd3);
        press(4'b0110);
        check("next_over_prev", 32'(der_a), 32'd1);
        press(4'b1000);
        check("mode_to_instr_sel", 32'(sel_a), 32'd0);
        check("mode_to_instr_idx", 32'(der_a), 32'd0);

        press(4'b0010);
        check("instr_prev_wrap", 32'(der_a), 32'd255);
        press(4'b0100);
        check("instr_next_wrap", 32'(der_a), 32'd0);
        press(4'b1100);
        check("mode_over_next_sel", 32'(sel_a), 32'd1);
        check("mode_over_next_idx", 32'(der_a), 32'd0);

        // Auto-advance in REG from index 30, period 4.
        press(4'b0010);
        press(4'b0010);
        check("reg_at_30", 32'(der_a), 32'd30);
        press(4'b0001);
        check("auto_on", 32'(act_a), 32'd1);
        tick(); tick();
        check("auto_hold_30", 32'(der_a), 32'd30);
        tick();
        check("auto_step_31", 32'(der_a), 32'd31);
        tick(); tick(); tick();
        check("auto_hold_31", 32'(der_a), 32'd31);
        tick();
        check("auto_step_0", 32'(der_a), 32'd0);
        tick(); tick(); tick();
        tick();
        check("auto_step_1", 32'(der_a), 32'd1);
        press(4'b0001);
        check("auto_off", 32'(act_a), 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check("auto_frozen", 32'(der_a), 32'd1);

        // A button held into the capture cycle counts once.
        nx_a = 1'b1;
        tick();
        tick();
        nx_a = 1'b0;
        tick();
        check("latch_ignores_btn", 32'(der_a), 32'd2);

        // MEM index 500, then reset together with buttons.
        press(4'b1000);
        for (int i = 0; i < 500; i++) press(4'b0100);
        check("mem_at_500", 32'(der_a), 32'd500);
        check("mem_capture_500", 32'(sa_a), 32'd500);
        rst = 1'b1;
        nx_a = 1'b1;
        au_a = 1'b1;
        tick();
        check("rst_override_sel", 32'(sel_a), 32'd0);
        check("rst_override_idx", 32'(der_a), 32'd0);
        check("rst_override_auto", 32'(act_a), 32'd0);
        rst = 1'b0;
        nx_a = 1'b0;
        au_a = 1'b0;
        tick();
        tick();
        check("post_rst_addr", 32'(sa_a), 32'd0);
        check("post_rst_word", sw_a, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
